// File: rtl/ringosc_tap_tuner.sv
// Ring-oscillator tap tuner: sweeps oscillator taps, counts edges per window, keeps the tap closest to target.
// Optional early exit on an exact match: define VBB_RINGOSC_TUNER_EARLY_EXIT_EN.
module ringosc_tap_tuner #(
    parameter int MAX_TAPS      = 4,
    parameter int TAPWIDTH      = $clog2(MAX_TAPS-1)+1,
    parameter int SETTLE_CYCLES = 4,
    parameter int WINDOW_BITS   = 10,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] target,
    input  logic                   osc_in,
    output logic [TAPWIDTH-1:0]    osc_tap,
    output logic                   osc_rst,
    output logic                   busy,
    output logic                   done,
    output logic [TAPWIDTH-1:0]    best_tap,
    output logic [COUNT_WIDTH-1:0] best_count
);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_EVAL, S_APPLY, S_DONE} state_t;

    localparam int SW = $clog2(SETTLE_CYCLES+1);
    localparam int CW = (WINDOW_BITS+1 > SW) ? WINDOW_BITS+1 : SW;
    localparam int HW = $clog2(SETTLE_CYCLES+2);
    localparam logic [CW-1:0]       SETTLE_LOAD = CW'(SETTLE_CYCLES-1);
    localparam logic [CW-1:0]       WINDOW_LOAD = CW'((2**WINDOW_BITS)-1);
    localparam logic [HW-1:0]       HOLD_INIT   = HW'(SETTLE_CYCLES+1);
    localparam logic [TAPWIDTH-1:0] LAST_TAP    = TAPWIDTH'(MAX_TAPS-1);

    state_t                 state, state_next;
    logic [1:0]             sync_q;
    logic                   sync_d;
    logic                   rise;
    logic [COUNT_WIDTH-1:0] edge_cnt;
    logic [COUNT_WIDTH-1:0] target_q;
    logic [COUNT_WIDTH-1:0] best_diff;
    logic [COUNT_WIDTH-1:0] diff;
    logic [CW-1:0]          cyc_cnt;
    logic [HW-1:0]          hold_cnt;
    logic                   phase_done;
    logic                   better;
    logic                   exit_sweep;

    assign rise       = sync_q[1] & ~sync_d;
    assign diff       = (edge_cnt >= target_q) ? edge_cnt - target_q : target_q - edge_cnt;
    assign better     = diff < best_diff;
    assign phase_done = (cyc_cnt == '0);
`ifdef VBB_RINGOSC_TUNER_EARLY_EXIT_EN
    assign exit_sweep = (osc_tap == LAST_TAP) || (diff == '0);
`else
    assign exit_sweep = (osc_tap == LAST_TAP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start && hold_cnt == '0) state_next = S_SETTLE;
            S_SETTLE:  if (phase_done) state_next = S_MEASURE;
            S_MEASURE: if (phase_done) state_next = S_EVAL;
            S_EVAL:    state_next = exit_sweep ? S_APPLY : S_SETTLE;
            S_APPLY:   if (phase_done) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        osc_rst = (state == S_SETTLE) || (state == S_APPLY) || (hold_cnt != '0);
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
    end

    // Phase counter reloads on every state change, so each timed state runs its full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            sync_d     <= 1'b0;
            edge_cnt   <= '0;
            target_q   <= '0;
            best_diff  <= '1;
            cyc_cnt    <= '0;
            hold_cnt   <= HOLD_INIT;
            osc_tap    <= '0;
            best_tap   <= '0;
            best_count <= '0;
        end else begin
            sync_q <= {sync_q[0], osc_in};
            sync_d <= sync_q[1];
            if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
            if (state_next != state)
                cyc_cnt <= (state_next == S_MEASURE) ? WINDOW_LOAD : SETTLE_LOAD;
            else if (cyc_cnt != '0)
                cyc_cnt <= cyc_cnt - 1'b1;
            case (state)
                S_IDLE: begin
                    if (state_next == S_SETTLE) begin
                        target_q  <= target;
                        osc_tap   <= '0;
                        best_diff <= '1;
                    end
                end
                S_SETTLE:  edge_cnt <= '0;
                S_MEASURE: if (rise && edge_cnt != '1) edge_cnt <= edge_cnt + 1'b1;
                S_EVAL: begin
                    if (better) begin
                        best_tap   <= osc_tap;
                        best_count <= edge_cnt;
                        best_diff  <= diff;
                    end
                    // The winner may be updated in this same cycle, so pick it from the live compare.
                    if (state_next == S_APPLY) osc_tap <= better ? osc_tap : best_tap;
                    else                       osc_tap <= osc_tap + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ringosc_tap_tuner.sv
// Testbench for ringosc_tap_tuner: behavioural oscillator, randomized targets/dividers, reference best-tap model.
`timescale 1ns/1ps
module tb_ringosc_tap_tuner;

    localparam int MAX_TAPS  = 4;
    localparam int TW        = 3;
    localparam int S         = 4;
    localparam int WIN       = 1024;
    localparam int TAP_COST  = S + WIN + 1;
    localparam int SWEEP_LAT = MAX_TAPS*TAP_COST + S + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   target = '0;
    logic          osc_in;
    logic [TW-1:0] osc_tap;
    logic          osc_rst;
    logic          busy;
    logic          done;
    logic [TW-1:0] best_tap;
    logic [15:0]   best_count;

    int n_checks = 0;
    int n_fail   = 0;
    int div_tab[4] = '{8, 12, 16, 20};
    int done_pulses = 0;
    int visited[$];

    ringosc_tap_tuner dut (
        .clk(clk), .rst_n(rst_n), .start(start), .target(target), .osc_in(osc_in),
        .osc_tap(osc_tap), .osc_rst(osc_rst), .busy(busy), .done(done),
        .best_tap(best_tap), .best_count(best_count)
    );

    always #5 clk = ~clk;

    // Oscillator: period div_tab[tap] clk cycles, held low while osc_rst, restarts off the clock grid.
    initial begin
        int half;
        osc_in = 1'b0;
        #2;
        forever begin
            if (osc_rst) begin
                osc_in = 1'b0;
                #1;
            end else begin
                #3;
                half = div_tab[osc_tap[1:0]] * 5;
                while (!osc_rst) begin
                    for (int t = 0; t < half && !osc_rst; t++) #1;
                    if (!osc_rst) osc_in = ~osc_in;
                end
                osc_in = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_pulses++;
        if (busy && !osc_rst && !done)
            if (visited.size() == 0 || visited[$] != int'(osc_tap)) visited.push_back(int'(osc_tap));
    end

    function automatic int nom(input int d);
        return WIN / d;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Nominal-count winner, whether it is immune to +-1 count jitter, and a jitter-safe bound on the best diff.
    function automatic void model_best(input int tgt, output int w, output bit robust, output int bound);
        int bd, lo, hi, dmin, dmax, wmax;
        bd = 65535; w = 0; bound = 1 << 30;
        for (int i = 0; i < MAX_TAPS; i++)
            if (iabs(nom(div_tab[i]) - tgt) < bd) begin bd = iabs(nom(div_tab[i]) - tgt); w = i; end
        wmax = (iabs(nom(div_tab[w]) - 1 - tgt) > iabs(nom(div_tab[w]) + 1 - tgt)) ?
               iabs(nom(div_tab[w]) - 1 - tgt) : iabs(nom(div_tab[w]) + 1 - tgt);
        robust = 1'b1;
        for (int j = 0; j < MAX_TAPS; j++) begin
            lo = nom(div_tab[j]) - 1; hi = nom(div_tab[j]) + 1;
            dmax = (iabs(lo - tgt) > iabs(hi - tgt)) ? iabs(lo - tgt) : iabs(hi - tgt);
            dmin = (tgt >= lo && tgt <= hi) ? 0 : ((iabs(lo - tgt) < iabs(hi - tgt)) ? iabs(lo - tgt) : iabs(hi - tgt));
            if (dmax < bound) bound = dmax;
            if (j != w && dmin <= wmax) robust = 1'b0;
        end
    endfunction

    task automatic run_sweep(input logic [15:0] tgt, output int lat, input int busy_start_at);
        bit ok;
        visited.delete();
        done_pulses = 0;
        @(negedge clk); target = tgt; start = 1'b1;
        @(negedge clk); start = 1'b0; target = 16'($urandom);
        lat = 1; ok = 1'b0;
        while (lat < SWEEP_LAT + 200) begin
            if (done) begin ok = 1'b1; break; end
            if (lat == busy_start_at) start = 1'b1;
            else start = 1'b0;
            @(negedge clk); lat++;
        end
        start = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL sweep_timeout: no done after %0d cycles, required within %0d", lat, SWEEP_LAT + 200);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({osc_rst, busy, done} !== 3'b100) begin
            n_fail++; $display("FAIL reset_ctrl: osc_rst/busy/done=%b required 100", {osc_rst, busy, done});
        end
        n_checks++;
        if (osc_tap !== '0 || best_tap !== '0 || best_count !== '0) begin
            n_fail++; $display("FAIL reset_data: osc_tap=%0d best_tap=%0d best_count=%0d required 0/0/0", osc_tap, best_tap, best_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            start = (k == 2);
            @(negedge clk);
            n_checks++;
            if (osc_rst !== (k <= S)) begin
                n_fail++; $display("FAIL reset_hold cycle %0d: osc_rst=%b required %b", k, osc_rst, (k <= S));
            end
            if (k >= 3) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++; $display("FAIL start_in_hold cycle %0d: busy=%b required 0", k, busy);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_sweep_target85();
        int lat;
        div_tab = '{8, 12, 16, 20};
        run_sweep(16'd85, lat, -1);
        n_checks++;
        if (best_tap !== 3'd1) begin n_fail++; $display("FAIL t85_best_tap: got %0d required 1", best_tap); end
        n_checks++;
        if (best_count < 16'd84 || best_count > 16'd86) begin
            n_fail++; $display("FAIL t85_best_count: got %0d required 84..86", best_count);
        end
        n_checks++;
        if (done_pulses != 1) begin n_fail++; $display("FAIL t85_done_once: got %0d pulses required 1", done_pulses); end
        n_checks++;
        if (osc_tap !== best_tap || busy !== 1'b0) begin
            n_fail++; $display("FAIL t85_idle: osc_tap=%0d busy=%b required %0d/0", osc_tap, busy, best_tap);
        end
`ifndef VBB_RINGOSC_TUNER_EARLY_EXIT_EN
        n_checks++;
        if (lat != SWEEP_LAT) begin n_fail++; $display("FAIL t85_latency: got %0d required %0d", lat, SWEEP_LAT); end
        begin
            bit seq_ok = (visited.size() == MAX_TAPS);
            for (int i = 0; i < visited.size(); i++) if (visited[i] != i) seq_ok = 1'b0;
            n_checks++;
            if (!seq_ok) begin n_fail++; $display("FAIL t85_taps_visited: got %0d distinct taps, required 0,1,2,3 in order", visited.size()); end
        end
`endif
    endtask

    task automatic test_target_max();
        int lat;
        div_tab = '{8, 12, 16, 20};
        run_sweep(16'hFFFF, lat, -1);
        n_checks++;
        if (best_tap !== 3'd0) begin n_fail++; $display("FAIL tmax_best_tap: got %0d required 0", best_tap); end
        n_checks++;
        if (best_count < 16'd127 || best_count > 16'd129) begin
            n_fail++; $display("FAIL tmax_best_count: got %0d required 127..129", best_count);
        end
        n_checks++;
        if (lat != SWEEP_LAT) begin n_fail++; $display("FAIL tmax_latency: got %0d required %0d", lat, SWEEP_LAT); end
    endtask

    task automatic test_tie();
        int lat;
        div_tab = '{20, 16, 16, 8};
        run_sweep(16'd64, lat, -1);
        n_checks++;
        if (best_tap !== 3'd1) begin n_fail++; $display("FAIL tie_lower_tap: got %0d required 1", best_tap); end
        n_checks++;
        if (best_count !== 16'd64) begin n_fail++; $display("FAIL tie_best_count: got %0d required 64", best_count); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        div_tab = '{8, 12, 16, 20};
        run_sweep(16'd64, lat, 2*TAP_COST + S + 300);
        n_checks++;
        if (done_pulses != 1) begin n_fail++; $display("FAIL busy_start_done_once: got %0d pulses required 1", done_pulses); end
        n_checks++;
        if (best_tap !== 3'd2) begin n_fail++; $display("FAIL busy_start_best_tap: got %0d required 2", best_tap); end
`ifndef VBB_RINGOSC_TUNER_EARLY_EXIT_EN
        n_checks++;
        if (lat != SWEEP_LAT) begin n_fail++; $display("FAIL busy_start_latency: got %0d required %0d", lat, SWEEP_LAT); end
`endif
        repeat (SWEEP_LAT / 4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done_pulses != 1) begin
            n_fail++; $display("FAIL busy_start_no_restart: busy=%b pulses=%0d required 0/1", busy, done_pulses);
        end
    endtask

    task automatic test_random();
        int lat, w, bound, got;
        bit robust;
        logic [15:0] tgt;
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < MAX_TAPS; i++) div_tab[i] = int'($urandom_range(4, 24));
            tgt = 16'($urandom_range(20, 260));
            model_best(int'(tgt), w, robust, bound);
            run_sweep(tgt, lat, -1);
            got = int'(best_count);
            n_checks++;
            if (best_tap >= 3'(MAX_TAPS) || got < nom(div_tab[best_tap[1:0]]) - 1 || got > nom(div_tab[best_tap[1:0]]) + 1) begin
                n_fail++; $display("FAIL rand%0d_count: tap=%0d count=%0d required %0d+-1", it, best_tap, got, nom(div_tab[best_tap[1:0]]));
            end
            n_checks++;
            if (iabs(got - int'(tgt)) > bound) begin
                n_fail++; $display("FAIL rand%0d_diff: |%0d-%0d| exceeds required bound %0d", it, got, tgt, bound);
            end
            if (robust) begin
                n_checks++;
                if (int'(best_tap) != w) begin n_fail++; $display("FAIL rand%0d_best_tap: got %0d required %0d", it, best_tap, w); end
            end
            n_checks++;
            if (done_pulses != 1) begin n_fail++; $display("FAIL rand%0d_done_once: got %0d required 1", it, done_pulses); end
`ifndef VBB_RINGOSC_TUNER_EARLY_EXIT_EN
            n_checks++;
            if (lat != SWEEP_LAT) begin n_fail++; $display("FAIL rand%0d_latency: got %0d required %0d", it, lat, SWEEP_LAT); end
`endif
        end
    endtask

    task automatic test_reset_mid_sweep();
        div_tab = '{8, 12, 16, 20};
        visited.delete();
        done_pulses = 0;
        @(negedge clk); target = 16'd85; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (TAP_COST + S + 500) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || osc_rst !== 1'b0) begin
            n_fail++; $display("FAIL midrst_pre: busy=%b osc_rst=%b required 1/0", busy, osc_rst);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({osc_rst, busy, done} !== 3'b100 || osc_tap !== '0 || best_tap !== '0 || best_count !== '0) begin
            n_fail++; $display("FAIL midrst_values: rst/busy/done=%b tap=%0d best=%0d cnt=%0d required 100/0/0/0",
                               {osc_rst, busy, done}, osc_tap, best_tap, best_count);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= S + 1; k++) begin
            @(negedge clk);
            n_checks++;
            if (osc_rst !== (k <= S)) begin
                n_fail++; $display("FAIL midrst_hold cycle %0d: osc_rst=%b required %b", k, osc_rst, (k <= S));
            end
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (done_pulses != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_no_done: pulses=%0d busy=%b required 0/0", done_pulses, busy);
        end
    endtask

`ifdef VBB_RINGOSC_TUNER_EARLY_EXIT_EN
    task automatic test_early_exit();
        int lat;
        div_tab = '{8, 12, 16, 20};
        run_sweep(16'd85, lat, -1);
        n_checks++;
        if (best_tap !== 3'd1 || best_count !== 16'd85) begin
            n_fail++; $display("FAIL early_best: tap=%0d count=%0d required 1/85", best_tap, best_count);
        end
        n_checks++;
        if (visited.size() != 2) begin n_fail++; $display("FAIL early_taps: got %0d taps measured required 2", visited.size()); end
        n_checks++;
        if (lat != 2*TAP_COST + S + 1) begin n_fail++; $display("FAIL early_latency: got %0d required %0d", lat, 2*TAP_COST + S + 1); end
    endtask
`endif

    initial begin
        test_reset();
        test_sweep_target85();
        test_reset_mid_sweep();
        repeat (8) @(negedge clk);
        test_target_max();
        test_tie();
        test_start_while_busy();
        test_random();
`ifdef VBB_RINGOSC_TUNER_EARLY_EXIT_EN
        test_early_exit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ringosc_tap_tuner.md
RINGOSC_TAP_TUNER -- requirements
Module: ringosc_tap_tuner

Interface
REQ-001 Parameter MAX_TAPS, default 4: number of oscillator taps swept, 0..MAX_TAPS-1; SHALL be >= 2.
REQ-002 Parameter TAPWIDTH, default $clog2(MAX_TAPS-1)+1: width of the tap bus; SHALL match the adjustable oscillator's tap input.
REQ-003 Parameter SETTLE_CYCLES, default 4: clk cycles osc_rst is held per tap change; SHALL be >= 1.
REQ-004 Parameter WINDOW_BITS, default 10: measurement window is 2**WINDOW_BITS clk cycles.
REQ-005 Parameter COUNT_WIDTH, default 16: width of edge counts and target.
REQ-006 clk  input  1  single system clock; all state on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to begin a sweep; ignored unless idle.
REQ-009 target  input  COUNT_WIDTH  desired edge count per window; sampled on accepted start.
REQ-010 osc_in  input  1  oscillator output, asynchronous to clk.
REQ-011 osc_tap  output  TAPWIDTH  tap select driven to the oscillator.
REQ-012 osc_rst  output  1  active-high oscillator reset.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse at sweep completion.
REQ-015 best_tap  output  TAPWIDTH  selected tap, valid when done or idle after a sweep.
REQ-016 best_count  output  COUNT_WIDTH  edge count measured for best_tap.

Function
REQ-017 osc_in SHALL pass a 2-flop synchronizer; a rising edge is a 0->1 transition of the synchronized value. Oscillator must run below clk/2; faster oscillators alias, and this is not detected.
REQ-018 FSM states: IDLE, SETTLE, MEASURE, EVAL, APPLY, DONE.
REQ-019 IDLE: start=1 -> latch target, osc_tap=0, best_diff=all-ones, busy=1, go SETTLE.
REQ-020 SETTLE: osc_rst=1 for exactly SETTLE_CYCLES cycles, then osc_rst=0, clear edge counter, go MEASURE.
REQ-021 MEASURE: count synchronized rising edges for exactly 2**WINDOW_BITS cycles; counter saturates at all-ones, never wraps; then go EVAL.
REQ-022 EVAL (1 cycle): diff=|count-target| at COUNT_WIDTH unsigned; if diff < best_diff (strict), update best_tap/best_count/best_diff; ties keep the lower tap.
REQ-023 EVAL exit: osc_tap < MAX_TAPS-1 -> osc_tap+1, go SETTLE; else go APPLY.
REQ-024 APPLY: osc_tap=best_tap, osc_rst=1 for SETTLE_CYCLES cycles, then go DONE.
REQ-025 DONE: done=1 one cycle, busy=0 next cycle, return to IDLE; osc_tap stays best_tap in IDLE.
REQ-026 start asserted while busy SHALL be ignored, with no effect on the sweep.
REQ-027 target changes while busy SHALL be ignored; only the latched value is used.
REQ-028 Sweep latency (macro off): MAX_TAPS*(SETTLE_CYCLES+2**WINDOW_BITS+1)+SETTLE_CYCLES+1 cycles from start to the done pulse.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, osc_tap=0, osc_rst=1, busy=0, done=0, best_tap=0, best_count=0, counters and synchronizer cleared.
REQ-030 After rst_n deasserts, osc_rst SHALL stay 1 for SETTLE_CYCLES cycles, then 0; start is not accepted during this interval.
REQ-031 Reset mid-sweep SHALL abort without a done pulse; the previous best values are lost.

Configuration
REQ-032 Macro VBB_RINGOSC_TUNER_EARLY_EXIT_EN defined: EVAL with diff==0 SHALL go directly to APPLY, skipping the remaining taps.
REQ-033 Macro not defined: all MAX_TAPS taps SHALL always be measured; no early-exit logic is present.

Verification
REQ-034 Defaults with osc model at clk/8, 12, 16, 20 for taps 0-3, target=85 -> taps measured 0,1,2,3; done once; best_tap=1, best_count≈85 (±1 for sync jitter).
REQ-035 Same setup, target=0xFFFF -> best_tap=0 (highest count); done-to-start latency exactly as REQ-028.
REQ-036 Two taps give equal diff -> best_tap is the lower tap index.
REQ-037 start pulsed again during MEASURE of tap 2 -> ignored; exactly one done pulse.
REQ-038 rst_n low mid-MEASURE -> outputs reach reset values immediately; no done; osc_rst held 4 cycles after release.
REQ-039 EARLY_EXIT_EN defined with an exact match at tap 1 -> taps 2 and 3 never selected; done follows tap-1 EVAL after APPLY.
